// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: one-hot state machine, instruction register, bypass, user DR channels.
// Define JTAG_TAP_IDCODE_EN to add the IDCODE register and make OPC_IDCODE the reset instruction.
module jtag_tap_ctrl #(
  parameter int          IR_WIDTH   = 4,
  parameter int          DR_WIDTH   = 32,
  parameter int          NUM_USER   = 2,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_563D,
  parameter int          OPC_IDCODE = 1,
  parameter int          OPC_USER0  = 8
) (
  input  logic                         tck,
  input  logic                         trst_n,
  input  logic                         tms,
  input  logic                         tdi,
  output logic                         tdo,
  output logic                         tdo_en,
  output logic [15:0]                  tap_state,
  output logic [IR_WIDTH-1:0]          ir_out,
  input  logic [NUM_USER*DR_WIDTH-1:0] user_cap,
  output logic [NUM_USER*DR_WIDTH-1:0] user_upd,
  output logic [NUM_USER-1:0]          user_upd_stb
);

  typedef enum logic [15:0] {
    TEST_LOGIC_RESET = 16'h0001,
    RUN_TEST_IDLE    = 16'h0002,
    SELECT_DR        = 16'h0004,
    CAPTURE_DR       = 16'h0008,
    SHIFT_DR         = 16'h0010,
    EXIT1_DR         = 16'h0020,
    PAUSE_DR         = 16'h0040,
    EXIT2_DR         = 16'h0080,
    UPDATE_DR        = 16'h0100,
    SELECT_IR        = 16'h0200,
    CAPTURE_IR       = 16'h0400,
    SHIFT_IR         = 16'h0800,
    EXIT1_IR         = 16'h1000,
    PAUSE_IR         = 16'h2000,
    EXIT2_IR         = 16'h4000,
    UPDATE_IR        = 16'h8000
  } tap_state_t;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_OPC = IR_WIDTH'(OPC_IDCODE);
`else
  localparam logic [IR_WIDTH-1:0] RESET_OPC = '1;
`endif

  if (IR_WIDTH < 2) begin : g_bad_ir_width
    $error("jtag_tap_ctrl: IR_WIDTH must be at least 2");
  end
  if (DR_WIDTH < 1) begin : g_bad_dr_width
    $error("jtag_tap_ctrl: DR_WIDTH must be at least 1");
  end
  if (NUM_USER < 1 || NUM_USER > 8) begin : g_bad_num_user
    $error("jtag_tap_ctrl: NUM_USER must be in 1..8");
  end
  if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
    $error("jtag_tap_ctrl: IDCODE_VAL bit 0 must be 1");
  end
  if (OPC_IDCODE >= (1 << IR_WIDTH)) begin : g_bad_opc_idcode
    $error("jtag_tap_ctrl: OPC_IDCODE does not fit in IR_WIDTH");
  end

  tap_state_t state_q, state_d;

  logic [IR_WIDTH-1:0] ir_sr;
  logic                bypass_q;
  logic [DR_WIDTH-1:0] user_sr [NUM_USER];
`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0]         idcode_sr;
`endif

  logic                sel_idcode;
  logic [NUM_USER-1:0] sel_user;
  logic                sel_bypass;
  logic                dr_lsb;
  logic                tdo_d;
  logic                tdo_en_d;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) state_q <= TEST_LOGIC_RESET;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = TEST_LOGIC_RESET;
    case (state_q)
      TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        state_d = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       state_d = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:         state_d = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:         state_d = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         state_d = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:         state_d = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        state_d = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_IR:        state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:         state_d = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:         state_d = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         state_d = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:         state_d = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        state_d = tms ? SELECT_DR : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  always_comb begin
    tap_state = state_q;
    tdo_en_d  = (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
    tdo_d     = 1'b0;
    if (state_q == SHIFT_IR)      tdo_d = ir_sr[0];
    else if (state_q == SHIFT_DR) tdo_d = dr_lsb;
  end

  // The all-ones opcode is always bypass, even if it collides with a user opcode.
  always_comb begin
    sel_idcode = 1'b0;
    sel_user   = '0;
`ifdef JTAG_TAP_IDCODE_EN
    sel_idcode = (ir_out == IR_WIDTH'(OPC_IDCODE)) && (ir_out != '1);
`endif
    for (int k = 0; k < NUM_USER; k++) begin
      if (!sel_idcode && (ir_out != '1) && (ir_out == IR_WIDTH'(OPC_USER0 + k)))
        sel_user[k] = 1'b1;
    end
    sel_bypass = !sel_idcode && (sel_user == '0);
  end

  always_comb begin
    dr_lsb = bypass_q;
`ifdef JTAG_TAP_IDCODE_EN
    if (sel_idcode) dr_lsb = idcode_sr[0];
`endif
    for (int k = 0; k < NUM_USER; k++) begin
      if (sel_user[k]) dr_lsb = user_sr[k][0];
    end
  end

  // ir_out reloads on the edge entering TEST_LOGIC_RESET so the reset instruction is visible there.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_sr  <= '0;
      ir_out <= RESET_OPC;
    end else begin
      if (state_q == CAPTURE_IR)    ir_sr <= IR_WIDTH'(1);
      else if (state_q == SHIFT_IR) ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
      if (state_d == TEST_LOGIC_RESET) ir_out <= RESET_OPC;
      else if (state_q == UPDATE_IR)   ir_out <= ir_sr;
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      bypass_q <= 1'b0;
    end else if (sel_bypass) begin
      if (state_q == CAPTURE_DR)    bypass_q <= 1'b0;
      else if (state_q == SHIFT_DR) bypass_q <= tdi;
    end
  end

`ifdef JTAG_TAP_IDCODE_EN
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      idcode_sr <= '0;
    end else if (sel_idcode) begin
      if (state_q == CAPTURE_DR)    idcode_sr <= IDCODE_VAL;
      else if (state_q == SHIFT_DR) idcode_sr <= {tdi, idcode_sr[31:1]};
    end
  end
`endif

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      for (int k = 0; k < NUM_USER; k++) user_sr[k] <= '0;
      user_upd     <= '0;
      user_upd_stb <= '0;
    end else begin
      user_upd_stb <= '0;
      for (int k = 0; k < NUM_USER; k++) begin
        if (sel_user[k]) begin
          if (state_q == CAPTURE_DR) begin
            user_sr[k] <= user_cap[k*DR_WIDTH +: DR_WIDTH];
          end else if (state_q == SHIFT_DR) begin
            user_sr[k] <= (user_sr[k] >> 1) | (DR_WIDTH'(tdi) << (DR_WIDTH - 1));
          end else if (state_q == UPDATE_DR) begin
            user_upd[k*DR_WIDTH +: DR_WIDTH] <= user_sr[k];
            user_upd_stb[k]                  <= 1'b1;
          end
        end
      end
    end
  end

  // TDO is launched on the falling edge so the host can sample it on the next rising edge.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo    <= tdo_d;
      tdo_en <= tdo_en_d;
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl: expected TDO bits are queued by the driver and popped by a monitor.
// Honours JTAG_TAP_IDCODE_EN the same way as the design.
module tb_jtag_tap_ctrl;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [3:0] RESET_OPC = 4'h1;
`else
  localparam logic [3:0] RESET_OPC = 4'hF;
`endif
  localparam logic [31:0] IDCODE = 32'h1000_563D;

  logic        tck = 1'b0;
  logic        trst_n = 1'b1;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        tdo;
  logic        tdo_en;
  logic [15:0] tap_state;
  logic [3:0]  ir_out;
  logic [63:0] user_cap = '0;
  logic [63:0] user_upd;
  logic [1:0]  user_upd_stb;

  int   asserts = 0;
  int   failures = 0;
  bit   exp_q[$];
  logic [63:0] exp_upd = '0;

  jtag_tap_ctrl dut (
    .tck(tck), .trst_n(trst_n), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_en(tdo_en), .tap_state(tap_state), .ir_out(ir_out),
    .user_cap(user_cap), .user_upd(user_upd), .user_upd_stb(user_upd_stb)
  );

  always #10 tck = ~tck;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // tdo and tdo_en only move on the falling edge, so the rising edge is a stable sample point.
  always @(posedge tck) begin : monitor
    bit exp_bit;
    if (tdo_en) begin
      if (exp_q.size() == 0) begin
        asserts++;
        failures++;
        $display("[TB] FAIL tdo_unexpected: got tdo_en=1 tdo=%b, expected no shift", tdo);
      end else begin
        exp_bit = exp_q.pop_front();
        check_output("tdo", 64'(tdo), 64'(exp_bit));
      end
    end else begin
      check_output("tdo_idle", 64'(tdo), 64'd0);
    end
  end

  task automatic step(input bit m, input bit d);
    tms = m;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic scan_ir(input logic [3:0] din);
    exp_q.push_back(1'b1);
    for (int i = 1; i < 4; i++) exp_q.push_back(1'b0);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    check_output("state_shift_ir", 64'(tap_state), 64'h0800);
    for (int i = 0; i < 4; i++) step(i == 3, din[i]);
    step(1, 0);
    check_output("state_update_ir", 64'(tap_state), 64'h8000);
    step(0, 0);
    check_output("ir_out", 64'(ir_out), 64'(din));
  endtask

  task automatic scan_dr(input int n, input logic [31:0] din, input logic [31:0] dout);
    for (int i = 0; i < n; i++) exp_q.push_back(dout[i]);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    check_output("state_shift_dr", 64'(tap_state), 64'h0010);
    for (int i = 0; i < n; i++) step(i == n - 1, din[i]);
    step(1, 0);
    check_output("state_update_dr", 64'(tap_state), 64'h0100);
    step(0, 0);
  endtask

  task automatic check_reset_values();
    check_output("rst_state", 64'(tap_state), 64'h0001);
    check_output("rst_ir_out", 64'(ir_out), 64'(RESET_OPC));
    check_output("rst_user_upd", user_upd, 64'd0);
    check_output("rst_stb", 64'(user_upd_stb), 64'd0);
    check_output("rst_tdo", 64'(tdo), 64'd0);
    check_output("rst_tdo_en", 64'(tdo_en), 64'd0);
  endtask

  task automatic apply_stimulus();
    user_cap = {32'h1234_5678, 32'hCAFE_0001};
    #1 trst_n = 1'b0;
    repeat (2) @(posedge tck);
    #1;
    check_reset_values();
    trst_n = 1'b1;
    step(1, 0);
    check_output("tlr_hold", 64'(tap_state), 64'h0001);
    step(0, 0);
    check_output("rti", 64'(tap_state), 64'h0002);

`ifdef JTAG_TAP_IDCODE_EN
    scan_dr(32, 32'h0, IDCODE);
`else
    scan_dr(5, 32'b01101, 32'b11010);
`endif
    check_output("no_stb_default", 64'(user_upd_stb), 64'd0);

    scan_ir(4'hF);
    scan_dr(5, 32'b01101, 32'b11010);
    check_output("bypass_upd", user_upd, exp_upd);

    scan_ir(4'h9);
    scan_dr(32, 32'hA5A5_0F0F, 32'h1234_5678);
    exp_upd[63:32] = 32'hA5A5_0F0F;
    check_output("ch1_upd", user_upd, exp_upd);
    check_output("ch1_stb", 64'(user_upd_stb), 64'h2);
    step(0, 0);
    check_output("ch1_stb_clear", 64'(user_upd_stb), 64'h0);

    scan_ir(4'h8);
    scan_dr(32, 32'h0BAD_F00D, 32'hCAFE_0001);
    exp_upd[31:0] = 32'h0BAD_F00D;
    check_output("ch0_upd", user_upd, exp_upd);
    check_output("ch0_stb", 64'(user_upd_stb), 64'h1);
    step(0, 0);
    check_output("ch0_stb_clear", 64'(user_upd_stb), 64'h0);

    // Capture straight to Exit1: no shift, but the update still loads the captured word.
    step(1, 0);
    step(0, 0);
    step(1, 0);
    check_output("state_exit1_dr", 64'(tap_state), 64'h0020);
    step(1, 0);
    step(0, 0);
    exp_upd[31:0] = 32'hCAFE_0001;
    check_output("cap_exit_upd", user_upd, exp_upd);
    check_output("cap_exit_stb", 64'(user_upd_stb), 64'h1);
    step(0, 0);

    scan_ir(4'hF);
    exp_q.push_back(1'b0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    repeat (5) step(1, 1);
    check_output("tms5_state", 64'(tap_state), 64'h0001);
    check_output("tms5_ir_out", 64'(ir_out), 64'(RESET_OPC));
    check_output("tms5_user_upd", user_upd, exp_upd);

    step(0, 0);
    scan_ir(4'h8);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    repeat (3) step(0, 1);
    trst_n = 1'b0;
    exp_upd = '0;
    #5;
    check_reset_values();
    repeat (3) @(posedge tck);
    #1;
    check_output("midrst_stb", 64'(user_upd_stb), 64'd0);
    check_output("midrst_state", 64'(tap_state), 64'h0001);
    trst_n = 1'b1;
    step(1, 0);
    check_output("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    apply_stimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
